dmi_req_bridge: RTL and testbench

//  Clock-domain (clk) consumer of the single-cycle DMI strobes from the JTAG DTM tap.

---
 rtl/dmi_pkg.sv | 15 +
 rtl/dmi_req_bridge.sv | 121 ++++++++++++
 tb/tb_dmi_req_bridge.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmi_pkg.sv
// Shared types for the DMI request bridge.
// State encoding and the op status codes seen by the DTM.
package dmi_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RSP
   } dmi_state_t;

   localparam logic [1:0] OP_OK     = 2'd0;
   localparam logic [1:0] OP_FAILED = 2'd2;
   localparam logic [1:0] OP_BUSY   = 2'd3;

endpackage

// File: rtl/dmi_req_bridge.sv
// Turns DTM strobes into one-outstanding valid/ready requests to the DM.
// Tracks the response, read data, sticky busy/failed status and timeout.
module dmi_req_bridge
   import dmi_pkg::*;
#(
   parameter int AWIDTH  = 7,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              dmi_reg_en,
   input  logic              dmi_reg_wr_en,
   input  logic [AWIDTH-1:0] dmi_reg_addr,
   input  logic [31:0]       dmi_reg_wdata,
   input  logic              dmi_hard_reset,
   output logic [31:0]       dmi_reg_rdata,
   output logic [1:0]        rd_status,
   output logic              dmi_busy,
   output logic              dm_req_valid,
   input  logic              dm_req_ready,
   output logic              dm_req_write,
   output logic [AWIDTH-1:0] dm_req_addr,
   output logic [31:0]       dm_req_wdata,
   input  logic              dm_rsp_valid,
   input  logic [31:0]       dm_rsp_rdata,
   input  logic              dm_rsp_err
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   dmi_state_t        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              valid_d, write_d;
   logic [AWIDTH-1:0] addr_d;
   logic [31:0]       wdata_d, rdata_d;
   logic [1:0]        status_d;
   logic              fail;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         dm_req_valid  <= 1'b0;
         dm_req_write  <= 1'b0;
         dm_req_addr   <= '0;
         dm_req_wdata  <= '0;
         dmi_reg_rdata <= '0;
         rd_status     <= OP_OK;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         dm_req_valid  <= valid_d;
         dm_req_write  <= write_d;
         dm_req_addr   <= addr_d;
         dm_req_wdata  <= wdata_d;
         dmi_reg_rdata <= rdata_d;
         rd_status     <= status_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      valid_d  = dm_req_valid;
      write_d  = dm_req_write;
      addr_d   = dm_req_addr;
      wdata_d  = dm_req_wdata;
      rdata_d  = dmi_reg_rdata;
      status_d = rd_status;
      fail     = 1'b0;
      if (dmi_hard_reset) begin
         state_d  = IDLE;
         valid_d  = 1'b0;
         status_d = OP_OK;
         cnt_d    = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (dmi_reg_en && rd_status == OP_OK) begin
                  write_d = dmi_reg_wr_en;
                  addr_d  = dmi_reg_addr;
                  wdata_d = dmi_reg_wdata;
                  valid_d = 1'b1;
                  state_d = REQ;
               end
            end
            REQ: begin
               if (dm_req_ready) begin
                  valid_d = 1'b0;
                  state_d = RSP;
                  cnt_d   = '0;
               end
            end
            RSP: begin
               cnt_d = cnt_q + CW'(1);
               // a response in the last counted cycle beats the timeout
               if (dm_rsp_valid) begin
                  state_d = IDLE;
                  if (dm_rsp_err)
                     fail = 1'b1;
                  else if (!dm_req_write)
                     rdata_d = dm_rsp_rdata;
               end else if (cnt_q == LAST) begin
                  state_d = IDLE;
                  fail    = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
         // busy always wins; failed only lands on a clean status
         if (dmi_reg_en && state_q != IDLE)
            status_d = OP_BUSY;
         else if (fail && rd_status == OP_OK)
            status_d = OP_FAILED;
      end
   end

   assign dmi_busy = (state_q != IDLE);

endmodule

// File: tb/tb_dmi_req_bridge.sv
// Directed bench for dmi_req_bridge with hand-computed expectations.
// Inputs change on negedge; outputs are checked on the following negedge.
module tb_dmi_req_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dmi_reg_en;
   logic        dmi_reg_wr_en;
   logic [6:0]  dmi_reg_addr;
   logic [31:0] dmi_reg_wdata;
   logic        dmi_hard_reset;
   logic [31:0] dmi_reg_rdata;
   logic [1:0]  rd_status;
   logic        dmi_busy;
   logic        dm_req_valid;
   logic        dm_req_ready;
   logic        dm_req_write;
   logic [6:0]  dm_req_addr;
   logic [31:0] dm_req_wdata;
   logic        dm_rsp_valid;
   logic [31:0] dm_rsp_rdata;
   logic        dm_rsp_err;

   int n_vec = 0;
   int n_err = 0;

   dmi_req_bridge #(
      .AWIDTH (7),
      .TIMEOUT(8)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .dmi_reg_en    (dmi_reg_en),
      .dmi_reg_wr_en (dmi_reg_wr_en),
      .dmi_reg_addr  (dmi_reg_addr),
      .dmi_reg_wdata (dmi_reg_wdata),
      .dmi_hard_reset(dmi_hard_reset),
      .dmi_reg_rdata (dmi_reg_rdata),
      .rd_status     (rd_status),
      .dmi_busy      (dmi_busy),
      .dm_req_valid  (dm_req_valid),
      .dm_req_ready  (dm_req_ready),
      .dm_req_write  (dm_req_write),
      .dm_req_addr   (dm_req_addr),
      .dm_req_wdata  (dm_req_wdata),
      .dm_rsp_valid  (dm_rsp_valid),
      .dm_rsp_rdata  (dm_rsp_rdata),
      .dm_rsp_err    (dm_rsp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic strobe(input logic wr, input logic [6:0] a,
                         input logic [31:0] d);
      dmi_reg_en    = 1'b1;
      dmi_reg_wr_en = wr;
      dmi_reg_addr  = a;
      dmi_reg_wdata = d;
      tick();
      dmi_reg_en    = 1'b0;
   endtask

   task automatic ready_now();
      dm_req_ready = 1'b1;
      tick();
      dm_req_ready = 1'b0;
   endtask

   task automatic respond(input logic [31:0] d, input logic e);
      dm_rsp_valid = 1'b1;
      dm_rsp_rdata = d;
      dm_rsp_err   = e;
      tick();
      dm_rsp_valid = 1'b0;
      dm_rsp_err   = 1'b0;
   endtask

   task automatic hard_reset();
      dmi_hard_reset = 1'b1;
      tick();
      dmi_hard_reset = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".valid"}, 32'(dm_req_valid), 32'd0);
      chk({tag, ".write"}, 32'(dm_req_write), 32'd0);
      chk({tag, ".addr"},  32'(dm_req_addr),  32'd0);
      chk({tag, ".wdata"}, dm_req_wdata,      32'd0);
      chk({tag, ".rdata"}, dmi_reg_rdata,     32'd0);
      chk({tag, ".status"}, 32'(rd_status),   32'd0);
      chk({tag, ".busy"},  32'(dmi_busy),     32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n          = 1'b0;
      dmi_reg_en     = 1'b0;
      dmi_reg_wr_en  = 1'b0;
      dmi_reg_addr   = '0;
      dmi_reg_wdata  = '0;
      dmi_hard_reset = 1'b0;
      dm_req_ready   = 1'b0;
      dm_rsp_valid   = 1'b0;
      dm_rsp_rdata   = '0;
      dm_rsp_err     = 1'b0;
      tick();
      tick();
      chk_reset_vals("por");
      rst_n = 1'b1;
      tick();

      // 1: read, ready at once, response three cycles into RSP
      strobe(1'b0, 7'h11, 32'h0);
      chk("rd.valid", 32'(dm_req_valid), 32'd1);
      chk("rd.addr",  32'(dm_req_addr),  32'h11);
      chk("rd.write", 32'(dm_req_write), 32'd0);
      chk("rd.busy",  32'(dmi_busy),     32'd1);
      ready_now();
      chk("rd.vdrop", 32'(dm_req_valid), 32'd0);
      chk("rd.rsp_busy", 32'(dmi_busy),  32'd1);
      tick();
      tick();
      respond(32'hDEADBEEF, 1'b0);
      chk("rd.rdata",  dmi_reg_rdata,  32'hDEADBEEF);
      chk("rd.status", 32'(rd_status), 32'd0);
      chk("rd.idle",   32'(dmi_busy),  32'd0);

      // 2: write held off by five cycles of backpressure
      strobe(1'b1, 7'h22, 32'h12345678);
      for (int i = 0; i < 5; i++) begin
         chk("wr.valid", 32'(dm_req_valid), 32'd1);
         chk("wr.addr",  32'(dm_req_addr),  32'h22);
         chk("wr.wdata", dm_req_wdata,      32'h12345678);
         chk("wr.write", 32'(dm_req_write), 32'd1);
         tick();
      end
      ready_now();
      respond(32'hAAAA5555, 1'b0);
      chk("wr.rdata",  dmi_reg_rdata,  32'hDEADBEEF);
      chk("wr.status", 32'(rd_status), 32'd0);
      chk("wr.idle",   32'(dmi_busy),  32'd0);

      // 3: second strobe while outstanding flags busy
      strobe(1'b0, 7'h33, 32'h0);
      ready_now();
      strobe(1'b0, 7'h34, 32'h0);
      chk("bz.status", 32'(rd_status),    32'd3);
      chk("bz.busy",   32'(dmi_busy),     32'd1);
      chk("bz.valid",  32'(dm_req_valid), 32'd0);
      respond(32'hCAFEF00D, 1'b0);
      chk("bz.rdata",  dmi_reg_rdata,  32'hCAFEF00D);
      chk("bz.sticky", 32'(rd_status), 32'd3);
      chk("bz.idle",   32'(dmi_busy),  32'd0);
      strobe(1'b0, 7'h35, 32'h0);
      chk("bz.drop_v", 32'(dm_req_valid), 32'd0);
      chk("bz.drop_b", 32'(dmi_busy),     32'd0);
      hard_reset();
      chk("bz.clear",  32'(rd_status),    32'd0);

      // 4: error response, dropped strobe, hard reset beats strobe
      strobe(1'b0, 7'h44, 32'h0);
      ready_now();
      respond(32'h0BADBAD0, 1'b1);
      chk("er.status", 32'(rd_status), 32'd2);
      chk("er.rdata",  dmi_reg_rdata,  32'hCAFEF00D);
      strobe(1'b0, 7'h45, 32'h0);
      chk("er.drop_v", 32'(dm_req_valid), 32'd0);
      chk("er.status2", 32'(rd_status),   32'd2);
      dmi_reg_en = 1'b1;
      hard_reset();
      dmi_reg_en = 1'b0;
      chk("hr.status", 32'(rd_status),    32'd0);
      chk("hr.valid",  32'(dm_req_valid), 32'd0);
      chk("hr.busy",   32'(dmi_busy),     32'd0);
      chk("hr.rdata",  dmi_reg_rdata,     32'hCAFEF00D);
      tick();
      chk("hr.valid2", 32'(dm_req_valid), 32'd0);

      // 5: timeout after eight cycles in RSP, late response ignored
      strobe(1'b0, 7'h55, 32'h0);
      ready_now();
      chk("to.rsp0", 32'(dmi_busy), 32'd1);
      for (int i = 1; i < 8; i++) begin
         tick();
         chk("to.busy",   32'(dmi_busy),  32'd1);
         chk("to.status", 32'(rd_status), 32'd0);
      end
      tick();
      chk("to.idle",   32'(dmi_busy),  32'd0);
      chk("to.status", 32'(rd_status), 32'd2);
      respond(32'h99999999, 1'b0);
      chk("to.late",   dmi_reg_rdata,  32'hCAFEF00D);
      chk("to.stat2",  32'(rd_status), 32'd2);
      hard_reset();

      // 6: asynchronous reset in RSP
      strobe(1'b0, 7'h66, 32'hFFFF0000);
      ready_now();
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("arst");
      tick();
      rst_n = 1'b1;
      respond(32'h44444444, 1'b0);
      chk("arst.ign", dmi_reg_rdata,  32'd0);
      chk("arst.idle", 32'(dmi_busy), 32'd0);
      strobe(1'b0, 7'h77, 32'h0);
      chk("post.valid", 32'(dm_req_valid), 32'd1);
      chk("post.addr",  32'(dm_req_addr),  32'h77);
      ready_now();
      respond(32'h13579BDF, 1'b0);
      chk("post.rdata",  dmi_reg_rdata,  32'h13579BDF);
      chk("post.status", 32'(rd_status), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
